pwm_servo_array: RTL and testbench

PWM_SERVO_ARRAY -- requirements
Module: pwm_servo_array

---
 rtl/pwm_servo_pkg.sv | 52 +++++
 rtl/pwm_servo_array_if.sv | 28 ++
 rtl/pwm_servo_channel.sv | 64 ++++++
 rtl/pwm_servo_array.sv | 81 ++++++++
 tb/tb_pwm_servo_array.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_servo_pkg.sv
// Shared constants and helpers for the servo PWM array.
// Limit math is widened so no parameter mix can overflow.
package pwm_servo_pkg;

  localparam int DUTY_W = 7;
  localparam int LIM_W  = 48;

  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_PERIOD    = 2000000;
  localparam int DEF_MIN_PULSE = 50000;
  localparam int DEF_STEP      = 2000;
  localparam int DEF_DUTY_MAX  = 99;
  localparam int DEF_SLEW      = 0;

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [LIM_W-1:0]  lim_t;

  function automatic lim_t pulse_limit(
    input duty_t       duty,
    input int unsigned min_p,
    input int unsigned step,
    input int unsigned period
  );
    lim_t sum;
    sum = lim_t'(min_p) + lim_t'(duty) * lim_t'(step);
    return (sum > lim_t'(period)) ? lim_t'(period) : sum;
  endfunction

  function automatic duty_t clamp_duty(
    input duty_t       d,
    input int unsigned dmax
  );
    return (32'(d) > dmax) ? duty_t'(dmax) : d;
  endfunction

  // Move act toward tgt by at most slew; slew of 0 jumps directly.
  function automatic duty_t slew_step(
    input duty_t       act,
    input duty_t       tgt,
    input int unsigned slew
  );
    duty_t diff;
    if (slew == 0) return tgt;
    if (tgt > act) begin
      diff = tgt - act;
      return (32'(diff) > slew) ? act + duty_t'(slew) : tgt;
    end
    diff = act - tgt;
    return (32'(diff) > slew) ? act - duty_t'(slew) : tgt;
  endfunction

endpackage

// File: rtl/pwm_servo_array_if.sv
// Duty-write handshake bundle for the servo PWM array.
// The array is the slave; a host or bench is the master.
interface pwm_servo_array_if
  import pwm_servo_pkg::*;
#(
  parameter int unsigned CH_W = 2
);

  logic            wr_valid;
  logic [CH_W-1:0] wr_ch;
  duty_t           wr_duty;
  logic            wr_ready;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_duty,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_duty,
    output wr_ready
  );

endinterface

// File: rtl/pwm_servo_channel.sv
// One servo channel: target/active duty, slew, enable latch, compare.
// Active duty and enable only change on the frame-end edge.
module pwm_servo_channel
  import pwm_servo_pkg::*;
#(
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
  parameter int unsigned SLEW      = DEF_SLEW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  duty_t            i_duty,
  input  logic             i_frame_end,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm,
  output logic             o_busy
);

  duty_t r_target;
  duty_t r_active;
  logic  r_en_q;
  logic  r_pwm;
  lim_t  w_limit;
  logic  w_hi;

  assign w_limit = pulse_limit(r_active, MIN_PULSE,
                               STEP, PERIOD);
  assign w_hi    = r_en_q && (lim_t'(i_cnt) < w_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
    end else if (i_wr) begin
      r_target <= clamp_duty(i_duty, DUTY_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
      r_en_q   <= 1'b0;
    end else if (i_frame_end) begin
      r_active <= slew_step(r_active, r_target, SLEW);
      r_en_q   <= i_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_hi;
    end
  end

  assign o_pwm  = r_pwm;
  assign o_busy = (r_active != r_target);

endmodule

// File: rtl/pwm_servo_array.sv
// Multi-channel servo PWM: shared frame counter, write decode,
// frame_start pulse, and one pwm_servo_channel per output.
module pwm_servo_array
  import pwm_servo_pkg::*;
#(
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned DUTY_MAX  = DEF_DUTY_MAX,
  parameter int unsigned SLEW      = DEF_SLEW,
  localparam int unsigned CH_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned CNT_W =
    (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  pwm_servo_array_if.slave    wr,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start,
  output logic [CHANNELS-1:0] busy
);

  logic [CNT_W-1:0]    r_cnt;
  logic                r_fs;
  logic                w_last;
  logic                w_acc;
  logic [CHANNELS-1:0] w_sel;

  assign w_last      = (r_cnt == CNT_W'(PERIOD - 1));
  assign wr.wr_ready = !w_last;
  assign w_acc       = wr.wr_valid && !w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered so it lines up with the first high pwm cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fs <= 1'b0;
    end else begin
      r_fs <= (r_cnt == '0);
    end
  end

  assign frame_start = r_fs;

  // Channel numbers past CHANNELS match nothing and are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_sel[c] = w_acc && (wr.wr_ch == CH_W'(c));

    pwm_servo_channel #(
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .MIN_PULSE(MIN_PULSE),
      .STEP     (STEP),
      .DUTY_MAX (DUTY_MAX),
      .SLEW     (SLEW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (reset),
      .i_wr       (w_sel[c]),
      .i_duty     (wr.wr_duty),
      .i_frame_end(w_last),
      .i_en       (ch_en[c]),
      .i_cnt      (r_cnt),
      .o_pwm      (pwm_out[c]),
      .o_busy     (busy[c])
    );
  end

endmodule

// File: tb/tb_pwm_servo_array.sv
// Bench: two arrays (slew 0 and 5) share stimulus; per-frame
// high counts are queued at each boundary and checked per frame.
module tb_pwm_servo_array;
  import pwm_servo_pkg::*;

  localparam int NCH  = 4;
  localparam int PER  = 100;
  localparam int MINP = 10;
  localparam int STP  = 1;
  localparam int DMAX = 99;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] pwm_a, pwm_b;
  logic [NCH-1:0] busy_a, busy_b;
  logic           fs_a, fs_b;

  pwm_servo_array_if #(.CH_W(2)) wa ();
  pwm_servo_array_if #(.CH_W(2)) wb ();

  always #5 clk = ~clk;

  pwm_servo_array #(
    .CHANNELS(NCH), .PERIOD(PER), .MIN_PULSE(MINP),
    .STEP(STP), .DUTY_MAX(DMAX), .SLEW(0)
  ) dut_a (
    .clk(clk), .reset(reset), .wr(wa),
    .ch_en(ch_en), .pwm_out(pwm_a),
    .frame_start(fs_a), .busy(busy_a)
  );

  pwm_servo_array #(
    .CHANNELS(NCH), .PERIOD(PER), .MIN_PULSE(MINP),
    .STEP(STP), .DUTY_MAX(DMAX), .SLEW(5)
  ) dut_b (
    .clk(clk), .reset(reset), .wr(wb),
    .ch_en(ch_en), .pwm_out(pwm_b),
    .frame_start(fs_b), .busy(busy_b)
  );

  typedef struct {
    int d;
    int f;
    int c;
    int hi;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  int             n;
  bit             model_on;
  int             tgt[2][NCH];
  int             act[2][NCH];
  int             slew_of[2];
  logic [NCH-1:0] en_m;

  task automatic check(input string nm,
                       input int actv, input int expv);
    tests++;
    if (actv != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, actv, expv);
    end
  endtask

  function automatic int exp_hi(input int d, input int c);
    int v;
    v = MINP + act[d][c] * STP;
    if (v > PER) v = PER;
    return en_m[c] ? v : 0;
  endfunction

  task automatic push_frame(input int f);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++)
        sbq.push_back('{d, f, c, exp_hi(d, c)});
  endtask

  task automatic frame_edge();
    int df;
    en_m = ch_en;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        df = tgt[d][c] - act[d][c];
        if (slew_of[d] == 0) act[d][c] = tgt[d][c];
        else if (df > slew_of[d]) act[d][c] += slew_of[d];
        else if (df < -slew_of[d]) act[d][c] -= slew_of[d];
        else act[d][c] = tgt[d][c];
      end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        tgt[d][c] = 0;
        act[d][c] = 0;
      end
    en_m = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (model_on && (n % PER == 0)) begin
      frame_edge();
      push_frame(n / PER);
    end
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  task automatic wr(input int ch, input int duty);
    bit ok;
    wa.wr_valid = 1'b1;
    wa.wr_ch    = 2'(ch);
    wa.wr_duty  = 7'(duty);
    wb.wr_valid = 1'b1;
    wb.wr_ch    = 2'(ch);
    wb.wr_duty  = 7'(duty);
    for (int k = 0; k < 3; k++) begin
      ok = (n % PER) != (PER - 1);
      check($sformatf("wr_ready_a_n%0d", n),
            int'(wa.wr_ready), int'(ok));
      check($sformatf("wr_ready_b_n%0d", n),
            int'(wb.wr_ready), int'(ok));
      if (ok)
        for (int d = 0; d < 2; d++)
          tgt[d][ch] = (duty > DMAX) ? DMAX : duty;
      tick();
      if (ok) break;
    end
    wa.wr_valid = 1'b0;
    wb.wr_valid = 1'b0;
  endtask

  // Frame monitor: counts high cycles between frame_start pulses.
  int             fidx[2];
  bit             started[2];
  int             cnt[2][NCH];
  logic [NCH-1:0] first[2];
  logic [NCH-1:0] mpw[2];
  logic           mfs[2];

  task automatic close_frame(input int d);
    int i;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].d == d && sbq[i].f <= fidx[d]) begin
        if (sbq[i].f < fidx[d]) begin
          check($sformatf("d%0d_f%0d_ch%0d_missed",
                          d, sbq[i].f, sbq[i].c),
                fidx[d], sbq[i].f);
        end else begin
          check($sformatf("d%0d_f%0d_ch%0d_high",
                          d, sbq[i].f, sbq[i].c),
                cnt[d][sbq[i].c], sbq[i].hi);
          check($sformatf("d%0d_f%0d_ch%0d_rise",
                          d, sbq[i].f, sbq[i].c),
                int'(first[d][sbq[i].c]),
                int'(sbq[i].hi != 0));
        end
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  always @(negedge clk) begin
    mpw[0] = pwm_a;
    mpw[1] = pwm_b;
    mfs[0] = fs_a;
    mfs[1] = fs_b;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        fidx[d]    = -1;
        started[d] = 1'b0;
      end else begin
        if (mfs[d]) begin
          if (started[d]) close_frame(d);
          fidx[d]++;
          started[d] = 1'b1;
          first[d]   = mpw[d];
          for (int c = 0; c < NCH; c++) cnt[d][c] = 0;
        end
        if (started[d])
          for (int c = 0; c < NCH; c++)
            cnt[d][c] += int'(mpw[d][c]);
      end
    end
  end

  initial begin
    slew_of[0]  = 0;
    slew_of[1]  = 5;
    reset       = 1'b0;
    ch_en       = 4'hF;
    wa.wr_valid = 1'b0;
    wa.wr_ch    = '0;
    wa.wr_duty  = '0;
    wb.wr_valid = 1'b0;
    wb.wr_ch    = '0;
    wb.wr_duty  = '0;
    model_on    = 1'b0;
    n           = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm_a", int'(pwm_a), 0);
    check("rst_pwm_b", int'(pwm_b), 0);
    check("rst_fs_a", int'(fs_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_ready_a", int'(wa.wr_ready), 1);

    reset    = 1'b1;
    n        = 0;
    model_on = 1'b1;
    push_frame(0);

    tick();
    wr(0, 20);
    wr(2, 120);

    run_to(50);
    check("busy_a_n50", int'(busy_a), 4'b0101);
    check("busy_b_n50", int'(busy_b), 4'b0101);
    run_to(101);
    check("busy_a_n101", int'(busy_a), 4'b0000);
    check("busy_b_n101", int'(busy_b), 4'b0101);

    run_to(199);
    wr(3, 40);

    run_to(305);
    ch_en = 4'b1101;

    run_to(350);
    check("busy_a_n350", int'(busy_a), 4'b0000);
    check("busy_b_n350", int'(busy_b), 4'b1101);
    run_to(401);
    check("busy_b_n401", int'(busy_b), 4'b1100);

    run_to(405);
    check("pre_rst_pwm_a", int'(pwm_a), 4'b1101);
    check("pre_rst_pwm_b", int'(pwm_b), 4'b1101);
    model_on = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_pwm_a", int'(pwm_a), 0);
    check("mid_rst_pwm_b", int'(pwm_b), 0);
    check("mid_rst_fs_a", int'(fs_a), 0);
    check("mid_rst_busy_a", int'(busy_a), 0);
    check("mid_rst_busy_b", int'(busy_b), 0);
    sbq.delete();
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    n        = 0;
    model_on = 1'b1;
    push_frame(0);

    run_to(5);
    check("post_rst_busy_a", int'(busy_a), 0);
    check("post_rst_busy_b", int'(busy_b), 0);
    run_to(50);
    check("post_rst_pwm_a", int'(pwm_a), 0);
    check("post_rst_pwm_b", int'(pwm_b), 0);

    run_to(100);
    model_on = 1'b0;
    run_to(205);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
